// File: rtl/cmul_sequencer_if.sv
// Port bundle for the complex-multiply sequencer: the sample/twiddle input
// handshake, the serial multiplier link and the result handshake.
//
// Handshake rules: a transfer happens on a rising edge where valid && ready
// are both high. A producer holds valid and its payload stable until that
// edge. A consumer may raise or drop ready freely. mul_start and mul_done
// are single-cycle strobes with no ready; mul_p is meaningful only while
// mul_done is high.
interface cmul_sequencer_if;
  // sample/twiddle input side
  logic                in_valid;
  logic                in_ready;
  logic signed [7:0]   a_re;
  logic signed [7:0]   a_im;
  logic signed [8:0]   w_re;
  logic signed [8:0]   w_im;
  // serial multiplier side
  logic                mul_start;
  logic signed [7:0]   mul_a;
  logic signed [8:0]   mul_b;
  logic                mul_done;
  logic signed [16:0]  mul_p;
  // result side
  logic                out_valid;
  logic                out_ready;
  logic signed [8:0]   y_re;
  logic signed [8:0]   y_im;

  // sequencer view
  modport master (
    input  in_valid, a_re, a_im, w_re, w_im, mul_done, mul_p, out_ready,
    output in_ready, mul_start, mul_a, mul_b, out_valid, y_re, y_im
  );

  // environment view (upstream source, multiplier, downstream sink)
  modport slave (
    output in_valid, a_re, a_im, w_re, w_im, mul_done, mul_p, out_ready,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, y_re, y_im
  );
endinterface

// File: rtl/cmul_sequencer.sv
// Complex-multiply sequencer. Computes y = a * w on a shared serial
// multiplier as four real partial products, then rounds (half toward +inf)
// and saturates each component to OUT_W bits.
//
// Product order: k0 a_re*w_re (+re), k1 a_im*w_im (-re),
//                k2 a_re*w_im (+im), k3 a_im*w_re (+im).
module cmul_sequencer #(
  parameter int ACC_W = 18,
  parameter int OUT_W = 9,
  parameter int FRAC  = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cmul_sequencer_if.master     bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int HALF_I = 1 << (FRAC - 1);
  localparam int MAX_I  = (1 << (OUT_W - 1)) - 1;
  localparam int MIN_I  = -(1 << (OUT_W - 1));
  localparam logic signed [ACC_W:0] HALF  = HALF_I[ACC_W:0];
  localparam logic signed [ACC_W:0] MAX_Y = MAX_I[ACC_W:0];
  localparam logic signed [ACC_W:0] MIN_Y = MIN_I[ACC_W:0];

  state_t                    state_q, state_d;
  logic [1:0]                k_q, k_d;
  logic signed [7:0]         a_re_q, a_re_d, a_im_q, a_im_d;
  logic signed [8:0]         w_re_q, w_re_d, w_im_q, w_im_d;
  logic signed [ACC_W-1:0]   acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic signed [7:0]         mul_a_q, mul_a_d;
  logic signed [8:0]         mul_b_q, mul_b_d;
  logic signed [OUT_W-1:0]   y_re_q, y_re_d, y_im_q, y_im_d;
  logic                      in_ready_q, in_ready_d;
  logic signed [ACC_W-1:0]   p_ext;

  // Round half toward +inf, arithmetic shift, clamp to the OUT_W range.
  function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;
    biased  = {acc[ACC_W-1], acc} + HALF;
    shifted = biased >>> FRAC;
    if (shifted > MAX_Y) begin
      shifted = MAX_Y;
    end else if (shifted < MIN_Y) begin
      shifted = MIN_Y;
    end
    return shifted[OUT_W-1:0];
  endfunction

  // State, operand, accumulator and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      a_re_q     <= '0;
      a_im_q     <= '0;
      w_re_q     <= '0;
      w_im_q     <= '0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      y_re_q     <= '0;
      y_im_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      a_re_q     <= a_re_d;
      a_im_q     <= a_im_d;
      w_re_q     <= w_re_d;
      w_im_q     <= w_im_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      y_re_q     <= y_re_d;
      y_im_q     <= y_im_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state, operand sequencing, accumulation and result capture.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_re_d   = a_re_q;
    a_im_d   = a_im_q;
    w_re_d   = w_re_q;
    w_im_d   = w_im_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    y_re_d   = y_re_q;
    y_im_d   = y_im_q;
    p_ext    = {{(ACC_W-17){bus.mul_p[16]}}, bus.mul_p};

    case (state_q)
      IDLE: begin
        // in_ready_q gates acceptance so the first cycle after reset is closed.
        if (bus.in_valid && in_ready_q) begin
          a_re_d   = bus.a_re;
          a_im_d   = bus.a_im;
          w_re_d   = bus.w_re;
          w_im_d   = bus.w_im;
          acc_re_d = '0;
          acc_im_d = '0;
          k_d      = 2'd0;
          mul_a_d  = bus.a_re;
          mul_b_d  = bus.w_re;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mul_done) begin
          case (k_q)
            2'd0:    acc_re_d = acc_re_q + p_ext;
            2'd1:    acc_re_d = acc_re_q - p_ext;
            default: acc_im_d = acc_im_q + p_ext;
          endcase
          if (k_q != 2'd3) begin
            k_d     = k_q + 2'd1;
            state_d = ISSUE;
            // Load operands for the next product so they are stable at its strobe.
            case (k_q)
              2'd0: begin
                mul_a_d = a_im_q;
                mul_b_d = w_im_q;
              end
              2'd1: begin
                mul_a_d = a_re_q;
                mul_b_d = w_im_q;
              end
              default: begin
                mul_a_d = a_im_q;
                mul_b_d = w_re_q;
              end
            endcase
          end else begin
            y_re_d  = round_sat(acc_re_d);
            y_im_d  = round_sat(acc_im_d);
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mul_start = (state_q == ISSUE);
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.out_valid = (state_q == OUT);
  assign bus.y_re      = y_re_q;
  assign bus.y_im      = y_im_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_cmul_sequencer.sv
// Bench for cmul_sequencer: driver tasks feed sample/twiddle pairs, a
// behavioural multiplier answers each strobe after a chosen latency, and a
// monitor pops expected results from a queue at every output handshake.
module tb_cmul_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;

  cmul_sequencer_if bus();

  cmul_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];   // {y_re, y_im}
  int          lexp_q[$];  // expected accept-to-out_valid latency
  int          lat_q[$];   // multiplier latency per product
  int          checks = 0;
  int          errors = 0;
  int          bp_cnt = 0;
  bit          spur_en = 1'b0;
  int          start_cnt = 0;
  bit          held = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact complex product, round half up, clamp to 9-bit signed.
  function automatic int rnd_sat(input int x);
    int r;
    r = (x + 64) >>> 7;
    if (r > 255) r = 255;
    if (r < -256) r = -256;
    return r;
  endfunction

  function automatic logic [17:0] ref_y(input int ar, input int ai, input int wr, input int wi);
    int re, im, yr, yi;
    re = ar * wr - ai * wi;
    im = ar * wi + ai * wr;
    yr = rnd_sat(re);
    yi = rnd_sat(im);
    return {yr[8:0], yi[8:0]};
  endfunction

  // ---------------- behavioural multiplier ----------------
  initial begin
    int cnt;
    int lat;
    int pa, pb;
    logic [16:0] prod;
    cnt = 0;
    prod = '0;
    bus.mul_done = 1'b0;
    bus.mul_p = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mul_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.mul_done = 1'b1;
          bus.mul_p = prod;
        end
      end else if (spur_en && (bus.mul_start || bus.out_valid)) begin
        bus.mul_done = 1'b1;
        bus.mul_p = 17'($urandom);
      end
      if (bus.mul_start && reset_n) begin
        pa = int'(bus.mul_a);
        pb = int'(bus.mul_b);
        prod = 17'(pa * pb);
        lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        cnt = lat;
      end
    end
  end

  // ---------------- downstream sink ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.out_valid && bp_cnt > 0) begin
        bus.out_ready = 1'b0;
        bp_cnt--;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int acc_cyc;
    int hold_re, hold_im;
    logic [17:0] e;
    acc_cyc = 0;
    hold_re = 0;
    hold_im = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held = 1'b0;
        start_cnt = 0;
      end else begin
        if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
        if (bus.mul_start) start_cnt++;
        if (bus.out_valid) begin
          if (!held) begin
            held = 1'b1;
            hold_re = int'(bus.y_re);
            hold_im = int'(bus.y_im);
            if (lexp_q.size() > 0) check("latency", cyc - acc_cyc, lexp_q.pop_front());
          end else begin
            check("y_re_stable", int'(bus.y_re), hold_re);
            check("y_im_stable", int'(bus.y_im), hold_im);
          end
          check("in_ready_busy", int'(bus.in_ready), 0);
          if (bus.out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out actual=out_valid required=no_output (t=%0t)", $time);
            end else begin
              e = exp_q.pop_front();
              check("y_re", int'($signed(e[17:9])), int'(bus.y_re));
              check("y_im", int'($signed(e[8:0])), int'(bus.y_im));
            end
            check("mul_starts", start_cnt, 4);
            start_cnt = 0;
            held = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int ar, input int ai, input int wr, input int wi,
                      input int l0, input int l1, input int l2, input int l3);
    int t;
    lat_q.push_back(l0);
    lat_q.push_back(l1);
    lat_q.push_back(l2);
    lat_q.push_back(l3);
    lexp_q.push_back(l0 + l1 + l2 + l3 + 4 + 1);
    exp_q.push_back(ref_y(ar, ai, wr, wi));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.a_re = ar[7:0];
    bus.a_im = ai[7:0];
    bus.w_re = wr[8:0];
    bus.w_im = wi[8:0];
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.in_ready && t < 300);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept (t=%0t)", $time);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() > 0 || held) && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0 || held) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0 (t=%0t)", exp_q.size(), $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"},  int'(bus.in_ready), 0);
    check({tag, "_mul_start"}, int'(bus.mul_start), 0);
    check({tag, "_mul_a"},     int'(bus.mul_a), 0);
    check({tag, "_mul_b"},     int'(bus.mul_b), 0);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_y_re"},      int'(bus.y_re), 0);
    check({tag, "_y_im"},      int'(bus.y_im), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    bus.in_valid = 1'b0;
    bus.a_re = '0;
    bus.a_im = '0;
    bus.w_re = '0;
    bus.w_im = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", int'(bus.in_ready), 1);
    check("release_state_idle", int'(dbg_state), 0);

    // identity, rotation by -j
    send(100, -50, 128, 0, 1, 1, 1, 1);
    drain();
    send(100, -50, 0, -128, 1, 1, 1, 1);
    drain();

    // saturation
    send(-128, -128, -256, -256, 1, 1, 1, 1);
    send(-128, 127, -256, 255, 2, 1, 1, 2);
    drain();

    // rounding boundaries
    send(1, 0, 64, 0, 1, 1, 1, 1);
    send(1, 0, 63, 0, 1, 1, 1, 1);
    send(-1, 0, 64, 0, 1, 1, 1, 1);
    drain();

    // backpressure, variable latency, spurious mul_done, ignored in_valid
    spur_en = 1'b1;
    bp_cnt = 6;
    send(77, -33, 100, -90, 1, 3, 1, 5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a_re = 8'sd127;
      bus.a_im = 8'sd127;
      bus.w_re = 9'sd255;
      bus.w_im = 9'sd255;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();
    spur_en = 1'b0;

    // reset in the middle of the third product's wait
    send(55, 66, 77, 88, 1, 1, 5, 1);
    t = 0;
    while (start_cnt < 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reached_k2", start_cnt, 3);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    lexp_q.delete();
    lat_q.delete();
    @(negedge clk);
    check_zero("midreset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_in_ready", int'(bus.in_ready), 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("stale_done_ignored_idle", int'(dbg_state), 0);
    check("stale_done_no_start", start_cnt, 0);
    send(10, 20, 128, 128, 1, 1, 1, 1);
    drain();

    // randomized pairs, latencies, backpressure and spurious strobes
    for (int n = 0; n < 25; n++) begin
      spur_en = 1'($urandom_range(0, 1));
      bp_cnt = int'($urandom_range(0, 3));
      send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
           int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
           int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
      drain();
    end
    spur_en = 1'b0;

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
